// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, instruction field positions and sequencer states shared by the ALU sequencer.
package alu_pkg;
    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_DEC = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_INC = 3'b111;
    localparam int B_CLASS = 15;
    localparam int OP_HI   = 14;
    localparam int OP_LO   = 12;
    localparam int RD_HI   = 11;
    localparam int RD_LO   = 9;
    localparam int RS_HI   = 8;
    localparam int RS_LO   = 6;
    localparam int RT_HI   = 5;
    localparam int RT_LO   = 3;
    localparam int LRD_HI  = 14;
    localparam int LRD_LO  = 12;
    localparam int IMM_HI  = 7;
    localparam int IMM_LO  = 0;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREG x W register file, one synchronous write port, three combinational read ports.
module alu_regfile #(
    parameter int NREG = 8,
    parameter int W    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_we,
    input  logic [$clog2(NREG)-1:0] i_wa,
    input  logic [W-1:0]            i_wd,
    input  logic [$clog2(NREG)-1:0] i_ra,
    input  logic [$clog2(NREG)-1:0] i_rb,
    input  logic [$clog2(NREG)-1:0] i_rdbg,
    output logic [W-1:0]            o_ra,
    output logic [W-1:0]            o_rb,
    output logic [W-1:0]            o_rdbg
);
    logic [W-1:0] r_mem [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_mem <= '{default: '0};
        else if (i_we)
            r_mem[i_wa] <= i_wd;
    end

    assign o_ra   = r_mem[i_ra];
    assign o_rb   = r_mem[i_rb];
    assign o_rdbg = r_mem[i_rdbg];
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts 16-bit instructions, drives an external combinational ALU,
// writes results back to the register file and reports each completion.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int NREG = 8,
    parameter int W    = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [15:0]  in_instr,
    output logic [2:0]   alu_opcode,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_q,
    input  logic         alu_ovf,
    output logic         res_valid,
    output logic [2:0]   res_rd,
    output logic [W-1:0] res_data,
    output logic         res_ovf,
    output logic         ovf_sticky,
    input  logic         ovf_clr,
    input  logic [2:0]   dbg_addr,
    output logic [W-1:0] dbg_data
);
    state_t       r_state, w_next;
    logic [W-1:0] w_rs_data, w_rt_data, r_a, r_b, r_data;
    logic [2:0]   r_opcode, r_rd;
    logic         r_ovf, r_sticky, w_accept, w_is_li, w_unused;

    assign w_is_li  = in_instr[B_CLASS];
    assign w_accept = in_valid && in_ready;
    assign w_unused = ^in_instr[2:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    w_next = w_is_li ? S_WB : S_EXEC;
            end
            S_EXEC: w_next = S_WB;
            S_WB: begin
                res_valid = 1'b1;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opcode <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rd     <= '0;
            r_data   <= '0;
            r_ovf    <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rd <= w_is_li ? in_instr[LRD_HI:LRD_LO] : in_instr[RD_HI:RD_LO];
                if (w_is_li) begin
                    r_data <= W'(in_instr[IMM_HI:IMM_LO]);
                    r_ovf  <= 1'b0;
                end else begin
                    r_opcode <= in_instr[OP_HI:OP_LO];
                    r_a      <= w_rs_data;
                    r_b      <= w_rt_data;
                end
            end
            // logic ops leave the ALU's ovf stale, so only arithmetic ops report it
            if (r_state == S_EXEC) begin
                r_data <= alu_q;
                r_ovf  <= r_opcode[2] && alu_ovf;
            end
            if (ovf_clr)
                r_sticky <= 1'b0;
            else if (res_valid)
                r_sticky <= r_sticky | r_ovf;
        end
    end

    alu_regfile #(.NREG(NREG), .W(W)) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .i_we   (res_valid),
        .i_wa   (r_rd),
        .i_wd   (r_data),
        .i_ra   (in_instr[RS_HI:RS_LO]),
        .i_rb   (in_instr[RT_HI:RT_LO]),
        .i_rdbg (dbg_addr),
        .o_ra   (w_rs_data),
        .o_rb   (w_rt_data),
        .o_rdbg (dbg_data)
    );

    assign alu_opcode = r_opcode;
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign res_rd     = r_rd;
    assign res_data   = r_data;
    assign res_ovf    = r_ovf;
    assign ovf_sticky = r_sticky;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: table vectors, corner-case sequences and random instructions against a reference model.
module tb_alu_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = '0;
    logic [2:0]  alu_opcode;
    logic [31:0] alu_a, alu_b, alu_q;
    logic        alu_ovf, arith_ovf, hold_ovf;
    logic        res_valid, res_ovf, ovf_sticky;
    logic        ovf_clr = 1'b0;
    logic [2:0]  res_rd;
    logic [31:0] res_data, dbg_data;
    logic [2:0]  dbg_addr = '0;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_mem [8];
    logic        m_sticky;

    typedef struct {
        logic [15:0] ins;
        logic [31:0] data;
        logic        ovf;
    } vec_t;
    vec_t tbl [8];

    alu_sequencer #(.NREG(8), .W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_q(alu_q), .alu_ovf(alu_ovf),
        .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data), .res_ovf(res_ovf),
        .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // ALU behaviour: {ovf, q}; carry/borrow for add/sub, sign change for inc/dec
    function automatic logic [32:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        case (op)
            3'b000: s = {1'b0, ~a};
            3'b001: s = {1'b0, a & b};
            3'b010: s = {1'b0, a ^ b};
            3'b011: s = {1'b0, a | b};
            3'b100: s = {a == 32'h8000_0000, a - 32'd1};
            3'b101: s = {1'b0, a} + {1'b0, b};
            3'b110: s = {a < b, a - b};
            default: s = {a == 32'h7FFF_FFFF, a + 32'd1};
        endcase
        return s;
    endfunction

    always_comb begin
        {arith_ovf, alu_q} = alu_fn(alu_opcode, alu_a, alu_b);
        alu_ovf = alu_opcode[2] ? arith_ovf : hold_ovf;
    end

    always @(posedge clk or posedge rst)
        if (rst) hold_ovf <= 1'b0;
        else if (alu_opcode[2]) hold_ovf <= arith_ovf;

    function automatic logic [32:0] ref_exec(input logic [15:0] ins);
        logic [32:0] r;
        if (ins[15]) return {25'b0, ins[7:0]};
        r = alu_fn(ins[14:12], m_mem[ins[8:6]], m_mem[ins[5:3]]);
        if (!ins[14]) r[32] = 1'b0;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // called at a negedge with the DUT idle; returns at a negedge with the DUT idle
    task automatic do_instr(input logic [15:0] ins, input logic [31:0] ed, input logic eo, input logic clr);
        int n;
        logic [2:0] rd;
        rd = ins[15] ? ins[14:12] : ins[11:9];
        in_valid = 1'b1;
        in_instr = ins;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1 && !ins[15]) begin
                chk("exec_opcode", 32'(alu_opcode), 32'(ins[14:12]));
                chk("exec_a", alu_a, m_mem[ins[8:6]]);
                chk("exec_b", alu_b, m_mem[ins[5:3]]);
                chk("exec_ready", 32'(in_ready), 32'd0);
            end
        end while (!res_valid && n < 6);
        chk("latency", n, ins[15] ? 32'd1 : 32'd2);
        chk("res_rd", 32'(res_rd), 32'(rd));
        chk("res_data", res_data, ed);
        chk("res_ovf", 32'(res_ovf), 32'(eo));
        ovf_clr = clr;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        m_mem[rd] = ed;
        m_sticky = clr ? 1'b0 : (m_sticky | eo);
        dbg_addr = rd;
        #1;
        chk("dbg_after_wb", dbg_data, ed);
        chk("sticky", 32'(ovf_sticky), 32'(m_sticky));
        chk("valid_after_wb", 32'(res_valid), 32'd0);
        chk("ready_after_wb", 32'(in_ready), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [32:0] r;
        logic [15:0] ins;
        logic        saw;
        tbl[0] = '{16'h9005, 32'h0000_0005, 1'b0};
        tbl[1] = '{16'hA003, 32'h0000_0003, 1'b0};
        tbl[2] = '{16'h5650, 32'h0000_0008, 1'b0};
        tbl[3] = '{16'h6888, 32'hFFFF_FFFE, 1'b1};
        tbl[4] = '{16'h1050, 32'h0000_0001, 1'b0};
        tbl[5] = '{16'hD000, 32'h0000_0000, 1'b0};
        tbl[6] = '{16'h0B40, 32'hFFFF_FFFF, 1'b0};
        tbl[7] = '{16'h7D40, 32'h0000_0000, 1'b0};
        for (int i = 0; i < 8; i++) m_mem[i] = '0;
        m_sticky = 1'b0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_opcode", 32'(alu_opcode), 32'd0);
        chk("rst_a", alu_a, 32'd0);
        chk("rst_b", alu_b, 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_rd", 32'(res_rd), 32'd0);
        chk("rst_data", res_data, 32'd0);
        chk("rst_ovf", 32'(res_ovf), 32'd0);
        chk("rst_sticky", 32'(ovf_sticky), 32'd0);
        chk("rst_dbg", dbg_data, 32'd0);
        @(negedge clk);

        for (int i = 0; i < 8; i++) do_instr(tbl[i].ins, tbl[i].data, tbl[i].ovf, 1'b0);

        ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        m_sticky = 1'b0;
        chk("clr_pulse", 32'(ovf_sticky), 32'd0);
        @(negedge clk);

        do_instr(16'h6888, 32'hFFFF_FFFE, 1'b1, 1'b1);

        do_instr(16'h9001, 32'd1, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_instr = 16'h5248;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            chk("b2b_valid", 32'(res_valid), 32'(c % 3 == 2));
            chk("b2b_ready", 32'(in_ready), 32'(c % 3 == 0));
            if (res_valid) begin
                chk("b2b_rd", 32'(res_rd), 32'd1);
                chk("b2b_data", res_data, 32'd1 << ((c + 1) / 3));
            end
        end
        in_valid = 1'b0;
        m_mem[1] = 32'd8;
        dbg_addr = 3'd1;
        #1 chk("b2b_final", dbg_data, 32'd8);
        @(negedge clk);

        in_valid = 1'b1;
        in_instr = 16'h5E50;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_opcode", 32'(alu_opcode), 32'd0);
        chk("mid_rst_a", alu_a, 32'd0);
        chk("mid_rst_b", alu_b, 32'd0);
        chk("mid_rst_data", res_data, 32'd0);
        chk("mid_rst_rd", 32'(res_rd), 32'd0);
        chk("mid_rst_sticky", 32'(ovf_sticky), 32'd0);
        saw = res_valid;
        repeat (4) begin
            @(negedge clk);
            saw |= res_valid;
        end
        chk("mid_rst_no_valid", 32'(saw), 32'd0);
        dbg_addr = 3'd7;
        #1 chk("mid_rst_r7", dbg_data, 32'd0);
        for (int i = 0; i < 8; i++) m_mem[i] = '0;
        m_sticky = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 150; k++) begin
            ins = 16'($urandom);
            r = ref_exec(ins);
            do_instr(ins, r[31:0], r[32], $urandom_range(0, 7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

- Initiator-side controller for the 3-bit-opcode, 32-bit combinational ALU.
- Accepts 16-bit instruction words over a valid/ready handshake and reads operands from an internal 8×32 register file.
- Drives the ALU's opcode and operand ports, captures its result and overflow, writes the result back, and reports each completion on a result port.
- Sits between the instruction-fetch front end and the ALU in the datapath.

## Interface
Parameters:
- NREG, 8, register-file depth (index width 3; fixed by the instruction format)
- W, 32, data width; must match the ALU

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  sequencer can accept an instruction
- in_instr  in  16  instruction word
- alu_opcode  out  3  to ALU `opcode`
- alu_a  out  W  to ALU `a`
- alu_b  out  W  to ALU `b`
- alu_q  in  W  from ALU `q`
- alu_ovf  in  1  from ALU `ovf`
- res_valid  out  1  one-cycle completion pulse
- res_rd  out  3  destination register of the completed instruction
- res_data  out  W  value written to `res_rd`
- res_ovf  out  1  overflow of the completed instruction
- ovf_sticky  out  1  OR of all `res_ovf` values since reset or clear
- ovf_clr  in  1  synchronous clear of `ovf_sticky`
- dbg_addr  in  3  debug register-file read index
- dbg_data  out  W  combinational read of `regfile[dbg_addr]`

## Operation
Instruction decode uses `in_instr[15]`.

ALU class (`in_instr[15]=0`):
- `[14:12]` is the opcode, passed through unchanged.
- `[11:9]` is rd, `[8:6]` is rs (→ `alu_a`), `[5:3]` is rt (→ `alu_b`).
- `[2:0]` is ignored.

Opcode semantics (these are ALU behaviour, not re-implemented here):
- 000 NOT a, 001 AND, 010 XOR, 011 OR.
- 100 a−1, 101 a+b, 110 a−b, 111 a+1.

Overflow rule:
- For opcodes 0xx (logic ops) the ALU does not update `ovf`, so `alu_ovf` is ignored and `res_ovf` = 0.
- For opcodes 1xx, `res_ovf` = `alu_ovf` sampled at capture.

Load-immediate class (`in_instr[15]=1`):
- `[14:12]` is rd.
- `[7:0]` is the immediate, zero-extended to W.
- `[11:8]` is ignored.
- `res_ovf` = 0.

State machine:
- **IDLE:** `in_ready`=1.
  - On `in_valid`, the instruction is accepted.
  - ALU class: register `alu_opcode`, `alu_a`=`regfile[rs]`, `alu_b`=`regfile[rt]`, latch rd; go to EXEC.
  - Load-immediate class: load the result register with the immediate, latch rd; go to WB.
- **EXEC:** `in_ready`=0. `alu_*` outputs are stable for the whole cycle. At the end of the cycle, capture `alu_q` into the result register and `alu_ovf` per the rule above; go to WB.
- **WB:** `in_ready`=0, `res_valid`=1. `res_rd`/`res_data`/`res_ovf` show the completed instruction. At the end of the cycle, write `regfile[rd]`, OR `res_ovf` into `ovf_sticky`, and go to IDLE.

Hold and reset behaviour:
- `alu_*` outputs hold their last values outside EXEC; they are not re-zeroed.
- `res_rd`/`res_data`/`res_ovf` hold their values after WB; they are meaningful only while `res_valid`=1.
- r0 is an ordinary register (not hardwired to zero).
- Reset clears all registers: `regfile` all 0, state IDLE.
  - Outputs after reset: `in_ready`=1, `alu_opcode`=0, `alu_a`=`alu_b`=0, `res_valid`=0, `res_rd`=0, `res_data`=0, `res_ovf`=0, `ovf_sticky`=0.
- Reset mid-EXEC or mid-WB abandons the instruction: no write-back, no `res_valid`.

Boundary rules:
- rd = rs = rt is legal. Operands are read at accept, so the old value is used.
- Back-to-back instructions are naturally hazard-free: the next accept happens only after the write-back edge.
- `ovf_clr` coinciding with the WB edge: clear wins, and `ovf_sticky`=0 afterwards, even if `res_ovf`=1.
- `in_valid` is ignored when `in_ready`=0. The source must hold its instruction until it sees a handshake.

## Timing
- Accept at edge 0. An ALU op is in EXEC during cycle 1 and WB during cycle 2; the write-back and return to IDLE happen at edge 3.
- ALU throughput: 1 instruction per 3 cycles. Load-immediate: WB in cycle 1, so 1 per 2 cycles.
- The ALU is combinational. `alu_q` must settle within the single EXEC cycle, which is a single-cycle path from the `alu_a`/`alu_b` registers back to the result register.
- `dbg_data` is combinational. It reflects a write from the edge after that write.

## Structure
- Shared package (`alu_pkg`):
  - Opcode constants: `OP_NOT`, `OP_AND`, `OP_XOR`, `OP_OR`, `OP_DEC`, `OP_ADD`, `OP_SUB`, `OP_INC`.
  - Instruction-field bit positions.
  - The state encoding (IDLE, EXEC, WB).
- One sub-module: `alu_regfile`, 8×W, with one synchronous write port, two combinational read ports (rs/rt) and a third combinational read port (dbg), all entries reset to 0.
- The ALU itself is instantiated by the parent, not by this block.

## Test plan
- Load immediate r1←0x05, r2←0x03, then ADD r3=r1+r2: `alu_opcode`=101, `alu_a`=5, `alu_b`=3 in EXEC; `res_valid` pulse with `res_rd`=3, `res_data`=8, `res_ovf`=0; `dbg_data`(3)=8.
- SUB r4=r2−r1 (3−5): `res_data`=0xFFFFFFFE, `res_ovf`=1 (borrow in `tmp[32]`), `ovf_sticky`=1; then pulse `ovf_clr` → `ovf_sticky`=0.
- Build r5=0xFFFFFFFF (load-immediate 0, then NOT), then INC r6=r5+1: `res_data`=0. `res_ovf` follows `alu_ovf` from the ALU's sign-change rule (0).
- AND immediately after an overflowing SUB: `res_ovf`=0 even though the ALU still holds `ovf`=1.
- Hold `in_valid` continuously with ADD r1=r1+r1 starting from r1=1: accepts every 3 cycles, and r1 reads 2, 4, 8 on successive `res_valid` pulses; `in_ready` is low in EXEC/WB.
- Assert `rst` during EXEC of ADD r7: no `res_valid`, r7 stays 0, all outputs at their reset values, `in_ready`=1 in the first cycle after release.
